// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD/binary converters: FSM state encoding and
// BCD digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd2bin_digit.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more after
// a right shift is pulled back by 3.
module bcd2bin_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Combinational digit correction
  always_comb begin
    if (d >= 4'd8) begin
      q = d - 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd2bin_multidigit.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// Optional input digit validity flag: define BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_multidigit
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int N_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] bcd,
  output logic [N_BITS-1:0]             bin,
  output logic                          ready,
  output logic                          busy,
`ifdef BCD2BIN_DIGIT_CHECK_EN
  output logic                          digit_err,
`endif
  output logic                          overflow
);

  localparam int BCD_W = N_DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  bcd_state_t        state_r, state_s;
  logic [BCD_W-1:0]  bcd_r, bcd_s;
  logic [N_BITS-1:0] bin_r, bin_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [N_BITS-1:0] bin_out_r, bin_out_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              ovf_r, ovf_s;

  logic [BCD_W-1:0]  shr_bcd_s;
  logic [BCD_W-1:0]  corr_bcd_s;
  logic [N_BITS-1:0] shr_bin_s;

  // The whole {bcd_r, bin_r} register moves right by one; the bit leaving
  // bcd_r enters the top of bin_r.
  assign shr_bcd_s = {1'b0, bcd_r[BCD_W-1:1]};
  assign shr_bin_s = {bcd_r[0], bin_r[N_BITS-1:1]};

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd2bin_digit u_digit (
      .d (shr_bcd_s[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (corr_bcd_s[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_r, err_s;
  logic bad_digit_s;

  // Flags any operand digit outside 0..9
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
        bad_digit_s = 1'b1;
      end else begin
        bad_digit_s = bad_digit_s;
      end
    end
  end
`endif

  // Next-state and next-register computation
  always_comb begin
    state_s   = state_r;
    bcd_s     = bcd_r;
    bin_s     = bin_r;
    cnt_s     = cnt_r;
    bin_out_s = bin_out_r;
    ovf_s     = ovf_r;
    ready_s   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_s     = err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          bcd_s   = bcd;
          bin_s   = '0;
          cnt_s   = '0;
          state_s = ST_SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_s   = bad_digit_s;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_s = corr_bcd_s;
        bin_s = shr_bin_s;
        cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // A nonzero residual means the decimal value does not fit in N_BITS.
        bin_out_s = bin_r;
        ovf_s     = (bcd_r != '0);
        ready_s   = 1'b1;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bcd_r     <= '0;
      bin_r     <= '0;
      cnt_r     <= '0;
      bin_out_r <= '0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bcd_r     <= bcd_s;
      bin_r     <= bin_s;
      cnt_r     <= cnt_s;
      bin_out_r <= bin_out_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      ovf_r     <= ovf_s;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  // Digit error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign digit_err = err_r;
`endif

  assign bin      = bin_out_r;
  assign ready    = ready_r;
  assign busy     = busy_r;
  assign overflow = ovf_r;

endmodule
